// File: rtl/rom_loader.sv
// rom_loader: assembles host bytes into little-endian words, writes them into the selected ROM,
// then reads the image back and compares XOR checksums while holding the system in reset.
module rom_loader #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic              rom_select,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wd,
    input  logic [31:0]       rom_rd,
    output logic              sys_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, WAIT, CHECK} state_t;

    state_t            state_q, state_d;
    logic [31:0]       word_q, word_d, csum_q, csum_d, rcsum_q, rcsum_d;
    logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d;
    logic [1:0]        bcnt_q, bcnt_d, wcnt_q, wcnt_d;
    logic              sel_q, sel_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              xfer, at_last, sample;
    logic              unused_hdr_bit;

    assign unused_hdr_bit = in_data[6];
    assign in_ready   = (state_q == IDLE) || (state_q == LOAD);
    assign xfer       = in_valid & in_ready;
    assign at_last    = addr_q == last_q;
    // With zero read latency the data is sampled in VERIFY itself; otherwise in the last WAIT cycle.
    assign sample     = (state_q == VERIFY && RD_LAT == 0) || (state_q == WAIT && wcnt_q == 2'(RD_LAT - 1));
    assign rom_we     = state_q == WRITE;
    assign rom_select = sel_q;
    assign rom_addr   = addr_q;
    assign rom_wd     = word_q;
    assign sys_hold   = busy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        csum_d  = csum_q;
        rcsum_d = rcsum_q;
        addr_d  = addr_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (xfer) begin
                sel_d   = in_data[7];
                last_d  = ADDR_W'(in_data[5:0]);
                done_d  = 1'b0;
                err_d   = 1'b0;
                csum_d  = '0;
                addr_d  = '0;
                bcnt_d  = '0;
                busy_d  = 1'b1;
                state_d = LOAD;
            end
            LOAD: if (xfer) begin
                word_d  = {in_data, word_q[31:8]};
                bcnt_d  = bcnt_q + 2'd1;
                state_d = bcnt_q == 2'd3 ? WRITE : LOAD;
            end
            WRITE: begin
                csum_d  = csum_q ^ word_q;
                addr_d  = at_last ? '0 : addr_q + ADDR_W'(1);
                rcsum_d = at_last ? '0 : rcsum_q;
                state_d = at_last ? VERIFY : LOAD;
            end
            VERIFY: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: wcnt_d = wcnt_q + 2'd1;
            CHECK: begin
                done_d  = rcsum_q == csum_q;
                err_d   = rcsum_q != csum_q;
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (sample) begin
            rcsum_d = rcsum_q ^ rom_rd;
            addr_d  = at_last ? addr_q : addr_q + ADDR_W'(1);
            state_d = at_last ? CHECK : VERIFY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            csum_q  <= '0;
            rcsum_q <= '0;
            addr_q  <= '0;
            last_q  <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            rcsum_q <= rcsum_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule
